// File: rtl/fip_det3_seq.sv
// fip_det3_seq: sequential 3x3 signed fixed-point determinant.
// One shared W x W multiplier is used over nine steps. Products,
// differences and the sum saturate, and saturation sets a sticky flag.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_matrix   : input handshake, 9 packed words
//   out_valid/out_ready           : output handshake
//   out_det, out_overflow         : result and saturation flag
module fip_det3_seq #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [9*W-1:0] in_matrix,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_det,
    output logic           out_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    state_t state_q, state_d;

    logic [8:0][W-1:0]   m_q;
    logic [3:0]          step_q;
    logic signed [W-1:0] t_q;
    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] p_q;
    logic                ov_q;

    logic signed [W-1:0]   op_a, op_b;
    logic signed [2*W-1:0] prod, prod_sh;
    logic signed [W-1:0]   p_sat, d_sat, s_sat;
    logic signed [W:0]     d_wide, s_wide;
    logic                  p_ov, d_ov, s_ov;
    logic                  mul_en, ld_t, use_d, add_en;

    // Step decode. The previous product is in p_q; the difference
    // feeding a*t, b*t and c*t is formed combinationally from t_q
    // and p_q so the multiplier never waits for it.
    always_comb begin
        op_a   = '0;
        op_b   = '0;
        mul_en = 1'b0;
        ld_t   = 1'b0;
        use_d  = 1'b0;
        add_en = 1'b0;
        unique case (step_q)
            4'd0: begin op_a = m_q[4]; op_b = m_q[8]; mul_en = 1'b1; end
            4'd1: begin op_a = m_q[5]; op_b = m_q[7]; mul_en = 1'b1;
                        ld_t = 1'b1; end
            4'd2: begin op_a = m_q[0]; op_b = d_sat; mul_en = 1'b1;
                        use_d = 1'b1; end
            4'd3: begin op_a = m_q[5]; op_b = m_q[6]; mul_en = 1'b1;
                        add_en = 1'b1; end
            4'd4: begin op_a = m_q[3]; op_b = m_q[8]; mul_en = 1'b1;
                        ld_t = 1'b1; end
            4'd5: begin op_a = m_q[1]; op_b = d_sat; mul_en = 1'b1;
                        use_d = 1'b1; end
            4'd6: begin op_a = m_q[3]; op_b = m_q[7]; mul_en = 1'b1;
                        add_en = 1'b1; end
            4'd7: begin op_a = m_q[4]; op_b = m_q[6]; mul_en = 1'b1;
                        ld_t = 1'b1; end
            4'd8: begin op_a = m_q[2]; op_b = d_sat; mul_en = 1'b1;
                        use_d = 1'b1; end
            4'd9: begin add_en = 1'b1; end
            default: begin end
        endcase
    end

    // Single shared multiplier, floor-scaled and saturated.
    assign prod    = op_a * op_b;
    assign prod_sh = prod >>> FRAC;
    assign p_ov    = !((&prod_sh[2*W-1:W-1]) || !(|prod_sh[2*W-1:W-1]));
    assign p_sat   = p_ov ? (prod_sh[2*W-1] ? MIN_V : MAX_V)
                          : prod_sh[W-1:0];

    assign d_wide = {t_q[W-1], t_q} - {p_q[W-1], p_q};
    assign d_ov   = d_wide[W] != d_wide[W-1];
    assign d_sat  = d_ov ? (d_wide[W] ? MIN_V : MAX_V) : d_wide[W-1:0];

    assign s_wide = {acc_q[W-1], acc_q} + {p_q[W-1], p_q};
    assign s_ov   = s_wide[W] != s_wide[W-1];
    assign s_sat  = s_ov ? (s_wide[W] ? MIN_V : MAX_V) : s_wide[W-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid && in_ready) state_d = CALC;
            CALC: if (step_q == 4'd9) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            step_q  <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_q    <= in_matrix;
                        step_q <= '0;
                        acc_q  <= '0;
                        ov_q   <= 1'b0;
                    end
                end
                CALC: begin
                    step_q <= step_q + 4'd1;
                    p_q    <= p_sat;
                    if (ld_t)   t_q   <= p_q;
                    if (add_en) acc_q <= s_sat;
                    ov_q <= ov_q | (mul_en & p_ov)
                                 | (use_d & d_ov)
                                 | (add_en & s_ov);
                end
                default: begin end
            endcase
        end
    end

    // Outputs are gated by state so reset clears them at once.
    assign in_ready     = (state_q == IDLE) && !reset;
    assign out_valid    = (state_q == DONE);
    assign out_det      = out_valid ? acc_q : '0;
    assign out_overflow = out_valid & ov_q;

endmodule

// File: tb/tb_fip_det3_seq.sv
// tb_fip_det3_seq: directed bench for fip_det3_seq, W=32 FRAC=16.
// Hand-computed determinants, latency, handshake and reset checks.
module tb_fip_det3_seq;

    localparam int W    = 32;
    localparam int FRAC = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [9*W-1:0] in_matrix = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_det;
    logic           out_overflow;

    int total = 0;
    int bad   = 0;

    fip_det3_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_matrix    (in_matrix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_det      (out_det),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*W-1:0] mk(
        input logic [W-1:0] a, b, c, d, e, f, g, h, i);
        return {i, h, g, f, e, d, c, b, a};
    endfunction

    function automatic logic [W-1:0] q(input int k);
        return W'(k * 65536);
    endfunction

    // Accept a matrix, wait for out_valid, check latency and result.
    // Leaves the DUT in DONE; out_ready is controlled by the caller.
    task automatic run(input string tag, input logic [9*W-1:0] m,
                       input logic [W-1:0] ed, input logic eo);
        int n;
        chk({tag, ".in_ready"}, W'(in_ready), 1);
        in_valid  = 1'b1;
        in_matrix = m;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_matrix = '1;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, W'(n), 10);
        chk({tag, ".det"}, out_det, ed);
        chk({tag, ".ovf"}, W'(out_overflow), W'(eo));
    endtask

    task automatic hs(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".idle_rdy"}, W'(in_ready), 1);
        chk({tag, ".idle_vld"}, W'(out_valid), 0);
    endtask

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] big;
        one = q(1);
        big = 32'h7FFF0000;

        #1;
        chk("rst.vld", W'(out_valid), 0);
        chk("rst.rdy", W'(in_ready), 0);
        chk("rst.det", out_det, 0);
        chk("rst.ovf", W'(out_overflow), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel.rdy", W'(in_ready), 1);

        run("ident", mk(one, 0, 0, 0, one, 0, 0, 0, one), 32'h00010000, 0);
        hs("ident");
        run("diag234", mk(q(2), 0, 0, 0, q(3), 0, 0, 0, q(4)),
            32'h00180000, 0);
        hs("diag234");
        run("full", mk(q(1), q(2), q(3), q(4), q(5), q(6),
                       q(7), q(8), q(10)), 32'hFFFD0000, 0);
        hs("full");
        run("sing", mk(q(1), q(2), q(3), q(4), q(5), q(6),
                       q(1), q(2), q(3)), 0, 0);
        hs("sing");
        run("zcol", mk(0, q(2), q(3), 0, q(5), q(6), 0, q(8), q(10)), 0, 0);
        hs("zcol");
        run("floor", mk(32'hFFFFFFFF, 0, 0, 0, 32'h00008000, 0,
                        0, 0, 32'h00008000), 32'hFFFFFFFF, 0);
        hs("floor");
        run("sat", mk(big, 0, 0, 0, big, 0, 0, 0, big), 32'h7FFFFFFF, 1);
        hs("sat");
        run("after_sat", mk(one, 0, 0, 0, one, 0, 0, 0, one),
            32'h00010000, 0);
        hs("after_sat");

        out_ready = 1'b0;
        run("hold", mk(q(2), 0, 0, 0, q(3), 0, 0, 0, q(4)), 32'h00180000, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_matrix = mk(one, one, one, one, one, one, one, one, one);
            @(posedge clk); #1;
            chk("hold.vld", W'(out_valid), 1);
            chk("hold.det", out_det, 32'h00180000);
            chk("hold.rdy", W'(in_ready), 0);
        end
        in_valid = 1'b0;
        hs("hold");

        in_valid  = 1'b1;
        in_matrix = mk(one, q(2), 0, q(3), one, 0, 0, 0, one);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.vld", W'(out_valid), 0);
        chk("midrst.rdy", W'(in_ready), 0);
        chk("midrst.det", out_det, 0);
        chk("midrst.ovf", W'(out_overflow), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst.rel_rdy", W'(in_ready), 1);
        chk("midrst.rel_vld", W'(out_valid), 0);
        run("post_rst", mk(one, 0, 0, 0, one, 0, 0, 0, one),
            32'h00010000, 0);
        hs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
